// File: rtl/fp_exc_pkg.sv
// Shared constants and types for the FPU exception controller: flag bit indices,
// the "no cause" code, FSM state encoding and the trap priority order.
package fp_exc_pkg;

    localparam int NFLAGS   = 6;
    localparam int FLG_DIVZ = 5;
    localparam int FLG_QNAN = 4;
    localparam int FLG_SNAN = 3;
    localparam int FLG_INEX = 2;
    localparam int FLG_OVFL = 1;
    localparam int FLG_UNFL = 0;

    localparam logic [2:0] CAUSE_NONE = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SERVICE = 2'd2
    } fsm_state_e;

    // Rank k (0 = highest priority) lives in bits [3k +: 3]:
    // SNaN, div_by_zero, overflow, underflow, QNaN, inexact.
    localparam logic [17:0] PRIO_ORDER = {3'd2, 3'd4, 3'd0, 3'd1, 3'd5, 3'd3};

endpackage

// File: rtl/fp_exception_controller_if.sv
// Flag/mask/status and interrupt handshake bundle between the FPU result stage,
// the sequencer and the exception controller (slave side).
interface fp_exception_controller_if;

    logic       fpu_valid;
    logic [5:0] fpu_flags;
    logic       mask_we;
    logic [5:0] mask_wdata;
    logic       status_clr;
    logic       irq_ack;
    logic       irq_done;
    logic       irq;
    logic [2:0] cause;
    logic [5:0] mask;
    logic       div_by_zero;
    logic       QNaN;
    logic       SNaN;
    logic       inexact;
    logic       overflow;
    logic       underflow;

    modport master (
        output fpu_valid, fpu_flags, mask_we, mask_wdata, status_clr, irq_ack, irq_done,
        input  irq, cause, mask, div_by_zero, QNaN, SNaN, inexact, overflow, underflow
    );

    modport slave (
        input  fpu_valid, fpu_flags, mask_we, mask_wdata, status_clr, irq_ack, irq_done,
        output irq, cause, mask, div_by_zero, QNaN, SNaN, inexact, overflow, underflow
    );

endinterface

// File: rtl/fp_exc_prio_enc.sv
// Picks the highest-priority set flag and returns its bit index (CAUSE_NONE if none).
import fp_exc_pkg::*;

module fp_exc_prio_enc (
    input  logic [5:0] flags,
    output logic [2:0] cause
);

    // Walk from lowest to highest rank so the last hit is the winner.
    always_comb begin
        cause = CAUSE_NONE;
        for (int k = NFLAGS - 1; k >= 0; k--) begin
            if (flags[PRIO_ORDER[3*k +: 3]]) begin
                cause = PRIO_ORDER[3*k +: 3];
            end
        end
    end

endmodule

// File: rtl/fp_exception_controller.sv
// Sticky IEEE-754 status, trap mask and prioritised interrupt handshake.
// Optional per-flag event counters are built when FP_EXC_COUNTERS_EN is defined.
import fp_exc_pkg::*;

module fp_exception_controller #(
    parameter int         CNT_W    = 8,
    parameter logic [5:0] MASK_RST = 6'b101000
) (
    input  logic                  clk,
    input  logic                  interrupt_reset,
    fp_exception_controller_if.slave bus
`ifdef FP_EXC_COUNTERS_EN
    ,
    input  logic [2:0]            cnt_sel,
    output logic [CNT_W-1:0]      cnt_rdata
`endif
);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] PENDING = ST_PENDING;
    localparam logic [1:0] SERVICE = ST_SERVICE;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic [1:0] state_q;
    logic [2:0] cause_q;
    logic [5:0] mask_q;
    logic [5:0] sticky_q;
    logic [5:0] deferred_q;
    logic [5:0] trap_flags;
    logic [5:0] pend_flags;
    logic [2:0] trap_cause;
    logic [2:0] pend_cause;

    // Trap detection always uses the mask as it stood before any same-cycle write.
    assign trap_flags = bus.fpu_valid ? (bus.fpu_flags & mask_q) : 6'b0;
    assign pend_flags = deferred_q | trap_flags;

    fp_exc_prio_enc u_prio_new (.flags(trap_flags), .cause(trap_cause));
    fp_exc_prio_enc u_prio_def (.flags(pend_flags), .cause(pend_cause));

    always_ff @(posedge clk) begin
        if (interrupt_reset) begin
            state_q    <= IDLE;
            cause_q    <= CAUSE_NONE;
            mask_q     <= MASK_RST;
            sticky_q   <= 6'b0;
            deferred_q <= 6'b0;
        end else begin
            if (bus.mask_we) begin
                mask_q <= bus.mask_wdata;
            end
            if (bus.status_clr) begin
                sticky_q <= bus.fpu_valid ? bus.fpu_flags : 6'b0;
            end else if (bus.fpu_valid) begin
                sticky_q <= sticky_q | bus.fpu_flags;
            end
            case (state_q)
                IDLE: begin
                    if (|trap_flags) begin
                        state_q <= PENDING;
                        cause_q <= trap_cause;
                    end
                end
                PENDING: begin
                    deferred_q <= pend_flags;
                    if (bus.irq_ack) begin
                        state_q <= SERVICE;
                    end
                end
                SERVICE: begin
                    // A trap landing on the irq_done cycle is folded into the re-raise.
                    if (bus.irq_done) begin
                        deferred_q <= 6'b0;
                        if (|pend_flags) begin
                            state_q <= PENDING;
                            cause_q <= pend_cause;
                        end else begin
                            state_q <= IDLE;
                            cause_q <= CAUSE_NONE;
                        end
                    end else begin
                        deferred_q <= pend_flags;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cause_q <= CAUSE_NONE;
                end
            endcase
        end
    end

    assign bus.irq         = (state_q == PENDING);
    assign bus.cause       = cause_q;
    assign bus.mask        = mask_q;
    assign bus.div_by_zero = sticky_q[FLG_DIVZ];
    assign bus.QNaN        = sticky_q[FLG_QNAN];
    assign bus.SNaN        = sticky_q[FLG_SNAN];
    assign bus.inexact     = sticky_q[FLG_INEX];
    assign bus.overflow    = sticky_q[FLG_OVFL];
    assign bus.underflow   = sticky_q[FLG_UNFL];

`ifdef FP_EXC_COUNTERS_EN
    logic [CNT_W-1:0] cnt_q [NFLAGS];

    // Counters see every retired flag regardless of mask and stick at all-ones.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NFLAGS; i++) begin
            if (interrupt_reset) begin
                cnt_q[i] <= '0;
            end else if (bus.status_clr) begin
                cnt_q[i] <= (bus.fpu_valid && bus.fpu_flags[i]) ? CNT_W'(1) : '0;
            end else if (bus.fpu_valid && bus.fpu_flags[i] && !(&cnt_q[i])) begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cnt_rdata = '0;
        if (cnt_sel < 3'(NFLAGS)) begin
            cnt_rdata = cnt_q[cnt_sel];
        end
    end
`endif

endmodule
